// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the CPU clock controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_STOPPED = 2'b11
  } clk_state_e;

  localparam int RUN_DIVIDE_DEFAULT = 4;

endpackage

// File: rtl/clock_divider_counter.sv
// Modulo-N counter with enable and synchronous clear.
// tc flags the last count while enabled.
module clock_divider_counter
  import clock_ctrl_pkg::*;
#(
  parameter int N = RUN_DIVIDE_DEFAULT,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/cpu_clock_controller.sv
// Run/pause/step/halt control producing the CPU clock-enable
// and a wrapping count of issued CPU cycles.
module cpu_clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int RUN_DIVIDE  = RUN_DIVIDE_DEFAULT,
  parameter int DIV_WIDTH   = 8,
  parameter int CYCLE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_toggle_edge,
  input  logic                   step_edge,
  input  logic                   halt_req,
  output logic                   cpu_clk_en,
  output logic                   running,
  output logic                   stopped,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  localparam longint MAX_DIV = longint'(1) << DIV_WIDTH;

  if (longint'(RUN_DIVIDE) < 1 ||
      longint'(RUN_DIVIDE) > MAX_DIV) begin : g_bad_div
    $fatal(1, "RUN_DIVIDE out of range");
  end

  clk_state_e state_q;
  clk_state_e state_d;

  logic [CYCLE_WIDTH-1:0] cycle_q;
  logic [CYCLE_WIDTH-1:0] cycle_d;

  logic div_tc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PAUSED: begin
        if (run_toggle_edge) begin
          state_d = ST_RUN;
        end else if (step_edge) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (run_toggle_edge) begin
          state_d = ST_PAUSED;
        end
      end
      ST_STEP:    state_d = ST_PAUSED;
      ST_STOPPED: state_d = ST_STOPPED;
    endcase
    // halt beats any button edge in the same cycle
    if (halt_req) begin
      state_d = ST_STOPPED;
    end
  end

  clock_divider_counter #(
    .N (RUN_DIVIDE),
    .W (DIV_WIDTH)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .clr   (state_d != ST_RUN),
    .tc    (div_tc)
  );

  assign cpu_clk_en = (state_q == ST_STEP) || div_tc;
  assign running    = (state_q == ST_RUN);
  assign stopped    = (state_q == ST_STOPPED);

  always_comb begin
    cycle_d = cycle_q;
    if (cpu_clk_en) begin
      cycle_d = cycle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PAUSED;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller: vector table plus hand sequences.
module tb_cpu_clock_controller;

  logic clk;
  logic rst_n;

  logic a_run, a_step, a_halt;
  logic a_en, a_rn, a_st;
  logic [3:0] a_cnt;

  logic b_run, b_step, b_halt;
  logic b_en, b_rn, b_st;
  logic [15:0] b_cnt;

  int checks;
  int failures;

  typedef struct {
    logic       run;
    logic       step;
    logic       halt;
    logic       en;
    logic       rn;
    logic       st;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  cpu_clock_controller #(
    .RUN_DIVIDE  (4),
    .DIV_WIDTH   (8),
    .CYCLE_WIDTH (4)
  ) dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .run_toggle_edge (a_run),
    .step_edge       (a_step),
    .halt_req        (a_halt),
    .cpu_clk_en      (a_en),
    .running         (a_rn),
    .stopped         (a_st),
    .cycle_count     (a_cnt)
  );

  cpu_clock_controller #(
    .RUN_DIVIDE  (1),
    .DIV_WIDTH   (8),
    .CYCLE_WIDTH (16)
  ) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .run_toggle_edge (b_run),
    .step_edge       (b_step),
    .halt_req        (b_halt),
    .cpu_clk_en      (b_en),
    .running         (b_rn),
    .stopped         (b_st),
    .cycle_count     (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic h,
                     input logic e, input logic rn, input logic st,
                     input logic [3:0] c);
    vec_t v;
    v.run = r; v.step = s; v.halt = h;
    v.en = e; v.rn = rn; v.st = st; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic e, input logic rn,
                      input logic st, input logic [3:0] c);
    for (int k = 0; k < n; k++) add(0, 0, 0, e, rn, st, c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    {a_run, a_step, a_halt} = '0;
    {b_run, b_step, b_halt} = '0;

    // three steps, five clocks apart
    add(0, 1, 0, 1, 0, 0, 0);
    addn(4, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1);
    addn(4, 0, 0, 0, 2);
    add(0, 1, 0, 1, 0, 0, 2);
    addn(2, 0, 0, 0, 3);
    // step edge during STEP is ignored
    add(0, 1, 0, 1, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 4);
    addn(1, 0, 0, 0, 4);
    // run for 20 clocks, divide by 4
    add(1, 0, 0, 0, 1, 0, 4);
    addn(2, 0, 1, 0, 4);
    addn(1, 1, 1, 0, 4);
    addn(3, 0, 1, 0, 5);
    addn(1, 1, 1, 0, 5);
    addn(1, 0, 1, 0, 6);
    add(0, 1, 0, 0, 1, 0, 6);
    addn(1, 0, 1, 0, 6);
    addn(1, 1, 1, 0, 6);
    addn(3, 0, 1, 0, 7);
    addn(1, 1, 1, 0, 7);
    addn(3, 0, 1, 0, 8);
    addn(1, 1, 1, 0, 8);
    add(1, 0, 0, 0, 0, 0, 9);
    addn(1, 0, 0, 0, 9);
    // simultaneous run and step while paused
    add(1, 1, 0, 0, 1, 0, 9);
    addn(2, 0, 1, 0, 9);
    addn(1, 1, 1, 0, 9);
    addn(1, 0, 1, 0, 10);
    add(1, 0, 0, 0, 0, 0, 10);
    addn(1, 0, 0, 0, 10);
    // divider restarts from zero on re-entry
    add(1, 0, 0, 0, 1, 0, 10);
    addn(2, 0, 1, 0, 10);
    addn(1, 1, 1, 0, 10);
    addn(1, 0, 1, 0, 11);
    add(1, 0, 0, 0, 0, 0, 11);
    // halt with a simultaneous step, then buttons ignored
    add(0, 1, 1, 0, 0, 1, 11);
    add(1, 0, 0, 0, 0, 1, 11);
    add(0, 1, 0, 0, 0, 1, 11);
    add(0, 0, 1, 0, 0, 1, 11);
    addn(1, 0, 0, 1, 11);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_en", a_en, 0);
    chk("rst_hold_cnt", a_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rst_a_en", a_en, 0);
    chk("rst_a_running", a_rn, 0);
    chk("rst_a_stopped", a_st, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_en", b_en, 0);
    chk("rst_b_running", b_rn, 0);
    chk("rst_b_stopped", b_st, 0);
    chk("rst_b_cnt", b_cnt, 0);

    // table-driven vectors through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      a_run  = vecs[i].run;
      a_step = vecs[i].step;
      a_halt = vecs[i].halt;
      exp_q.push_back(vecs[i]);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_en", i), a_en, e.en);
      chk($sformatf("vec%0d_running", i), a_rn, e.rn);
      chk($sformatf("vec%0d_stopped", i), a_st, e.st);
      chk($sformatf("vec%0d_cnt", i), a_cnt, e.cnt);
    end
    {a_run, a_step, a_halt} = '0;

    // divide-by-1 run is continuous, then halt
    b_run = 1'b1;
    tick();
    b_run = 1'b0;
    chk("b_run_en", b_en, 1);
    chk("b_run_running", b_rn, 1);
    chk("b_run_cnt0", b_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("b_cont_en%0d", k), b_en, 1);
      chk($sformatf("b_cont_cnt%0d", k), b_cnt, k);
    end
    b_halt = 1'b1;
    tick();
    b_halt = 1'b0;
    chk("b_halt_en", b_en, 0);
    chk("b_halt_stopped", b_st, 1);
    chk("b_halt_running", b_rn, 0);
    chk("b_halt_cnt", b_cnt, 4);
    b_run = 1'b1;
    b_step = 1'b1;
    tick();
    b_run = 1'b0;
    b_step = 1'b0;
    chk("b_stop_btn_en", b_en, 0);
    chk("b_stop_btn_stopped", b_st, 1);
    tick();
    chk("b_stop_idle_en", b_en, 0);
    chk("b_stop_idle_cnt", b_cnt, 4);

    // async reset leaves STOPPED without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_a_stopped", a_st, 0);
    chk("async_b_stopped", b_st, 0);
    chk("async_b_cnt", b_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // async reset mid-STEP drops the enable at once
    a_step = 1'b1;
    tick();
    a_step = 1'b0;
    chk("midstep_en", a_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midstep_rst_en", a_en, 0);
    chk("midstep_rst_cnt", a_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_en", a_en, 0);
    chk("post_rst_cnt", a_cnt, 0);

    // 4-bit cycle counter wraps after 16 steps
    for (int i = 1; i <= 17; i++) begin
      a_step = 1'b1;
      tick();
      a_step = 1'b0;
      tick();
      if (i == 15 || i == 16) begin
        chk($sformatf("wrap_cnt%0d", i), a_cnt, i % 16);
      end
    end
    chk("wrap_cnt17", a_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
